fma_issue_ctrl: RTL and testbench

// Initiator for the posit FMA core (out = A*B + C*D). Accepts operand quads over a valid/ready stream
// and drives the core's start/A..D/in_pre/out_pre inputs. Tracks in-flight ops by a fixed-latency tag

---
 rtl/fma_issue_ctrl_pkg.sv | 27 ++
 rtl/fma_issue_ctrl_if.sv | 65 ++++++
 rtl/fma_res_fifo.sv | 70 +++++++
 rtl/fma_issue_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fma_issue_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fma_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fma_issue_ctrl_pkg
// Shared definitions for the posit FMA issue controller:
//   - precision mode codes used on in_pre / out_pre
//   - issue FSM state encoding (exported on the debug port)
//   - default parameter values and the data word width
// ---------------------------------------------------------------------------
package fma_issue_ctrl_pkg;

  localparam int WORD_W       = 32;
  localparam int DEF_CORE_LAT = 7;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_TAG_W    = 4;

  typedef enum logic [1:0] {
    PRE_P32   = 2'd0,
    PRE_P16X2 = 2'd1,
    PRE_P8X4  = 2'd2
  } pre_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fma_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// fma_issue_ctrl_if
// Bundles the three streams around the issue controller:
//   in_*   : operand quad stream from the host (valid/ready)
//   core_* : issue bus to the FMA core plus its result strobe
//   res_*  : result stream back to the host (valid/ready), plus sticky err
// Modports:
//   master : the issue controller
//   slave  : the environment (host datapath and FMA core)
//
// Handshake rule for both in_* and res_* streams: a transfer happens on a
// rising clk edge where valid and ready are both high. The controller's
// in_ready may depend combinationally on in_in_pre and its own state; the
// result stream's res_valid depends only on registered state.
// ---------------------------------------------------------------------------
interface fma_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  import fma_issue_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_a;
  logic [WORD_W-1:0] in_b;
  logic [WORD_W-1:0] in_c;
  logic [WORD_W-1:0] in_d;
  logic [1:0]        in_in_pre;
  logic [1:0]        in_out_pre;
  logic [TAG_W-1:0]  in_tag;

  logic              core_start;
  logic [WORD_W-1:0] core_a;
  logic [WORD_W-1:0] core_b;
  logic [WORD_W-1:0] core_c;
  logic [WORD_W-1:0] core_d;
  logic [1:0]        core_in_pre;
  logic [1:0]        core_out_pre;
  logic [WORD_W-1:0] core_out;
  logic              core_soe;

  logic              res_valid;
  logic              res_ready;
  logic [WORD_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              err;

  modport master (
    input  in_valid, in_a, in_b, in_c, in_d, in_in_pre, in_out_pre, in_tag,
    output in_ready,
    output core_start, core_a, core_b, core_c, core_d, core_in_pre, core_out_pre,
    input  core_out, core_soe,
    output res_valid, res_data, res_tag, err,
    input  res_ready
  );

  modport slave (
    output in_valid, in_a, in_b, in_c, in_d, in_in_pre, in_out_pre, in_tag,
    input  in_ready,
    input  core_start, core_a, core_b, core_c, core_d, core_in_pre, core_out_pre,
    output core_out, core_soe,
    input  res_valid, res_data, res_tag, err,
    output res_ready
  );

endinterface

// File: rtl/fma_res_fifo.sv
// ---------------------------------------------------------------------------
// fma_res_fifo
// Show-ahead result FIFO, DEPTH entries of W bits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data this cycle
//   i_data     : entry to write
//   i_pop      : consume the head entry (ignored when empty)
//   o_data     : head entry, forced to zero while empty
//   o_valid    : FIFO not empty
//   o_count    : current occupancy (0..DEPTH)
// Push and pop may happen together at any occupancy, including full.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fma_res_fifo #(
  parameter int  DEPTH = 8,
  parameter int  W     = 36,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop & o_valid;
  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push  = i_push & (~w_full | w_pop);

  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // The upstream credit scheme guarantees this never happens.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && w_full && !i_pop));

endmodule

// File: rtl/fma_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fma_issue_ctrl
// Issue controller for the posit FMA core (out = A*B + C*D).
// Accepts operand quads on bus.in_*, registers them onto bus.core_* with a
// one-cycle core_start strobe, follows each op through a CORE_LAT-deep tag
// pipe and captures the core's out/soe into a result FIFO on bus.res_*.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (master)     : in_* / core_* / res_* streams and sticky err
//   o_dbg_state      : issue FSM state
//   o_dbg_in_flight  : ops issued to the core and not yet retired
// Credit: the core cannot stall, so an op is only issued while
// in_flight + capture register + FIFO occupancy < DEPTH; every issued op
// therefore always has a FIFO slot waiting for it.
// Precision changes are only issued into an empty core (DRAIN state).
// ---------------------------------------------------------------------------
module fma_issue_ctrl
  import fma_issue_ctrl_pkg::*;
#(
  parameter int  CORE_LAT = DEF_CORE_LAT,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  TAG_W    = DEF_TAG_W,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  fma_issue_ctrl_if.master bus,
  output state_e           o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_in_flight
);

  localparam int LAST = CORE_LAT - 1;
  localparam int UW   = CNT_W + 1;
  localparam int EW   = WORD_W + TAG_W;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_in_flight;
  logic [1:0]        r_cur_pre;

  logic              r_core_start;
  logic [WORD_W-1:0] r_core_a;
  logic [WORD_W-1:0] r_core_b;
  logic [WORD_W-1:0] r_core_c;
  logic [WORD_W-1:0] r_core_d;
  logic [1:0]        r_core_in_pre;
  logic [1:0]        r_core_out_pre;
  logic [TAG_W-1:0]  r_core_tag;

  logic [CORE_LAT-1:0] r_due;
  logic [TAG_W-1:0]    r_ptag [CORE_LAT];

  logic              r_cap_valid;
  logic [WORD_W-1:0] r_cap_data;
  logic [TAG_W-1:0]  r_cap_tag;
  logic              r_err;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_retire;
  logic              w_capture;
  logic              w_credit_ok;
  logic              w_pre_same;
  logic              w_none_in_flight;
  logic [UW-1:0]     w_used;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [EW-1:0]     w_fifo_dout;
  logic              w_fifo_valid;
  logic              w_pop;

  // ---------------- credit and FSM ----------------
  // The capture register holds an op that has left the core but not yet
  // reached the FIFO; it still owns a slot.
  assign w_used           = UW'(r_in_flight) + UW'(r_cap_valid) + UW'(w_fifo_count);
  assign w_credit_ok      = (w_used < UW'(DEPTH));
  assign w_pre_same       = (bus.in_in_pre == r_cur_pre);
  assign w_none_in_flight = (r_in_flight == '0);
  assign w_accept         = bus.in_valid & w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_in_ready = w_credit_ok & (w_pre_same | w_none_in_flight);
        if (bus.in_valid & w_credit_ok & ~w_pre_same & ~w_none_in_flight) begin
          w_state_nxt = DRAIN;
        end else if (~bus.in_valid & w_none_in_flight) begin
          w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (w_none_in_flight) w_state_nxt = ISSUE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- issue registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_start   <= 1'b0;
      r_core_a       <= '0;
      r_core_b       <= '0;
      r_core_c       <= '0;
      r_core_d       <= '0;
      r_core_in_pre  <= '0;
      r_core_out_pre <= '0;
      r_core_tag     <= '0;
      r_cur_pre      <= PRE_P32;
    end else begin
      r_core_start <= w_accept;
      if (w_accept) begin
        r_core_a       <= bus.in_a;
        r_core_b       <= bus.in_b;
        r_core_c       <= bus.in_c;
        r_core_d       <= bus.in_d;
        r_core_in_pre  <= bus.in_in_pre;
        r_core_out_pre <= bus.in_out_pre;
        r_core_tag     <= bus.in_tag;
        r_cur_pre      <= bus.in_in_pre;
      end
    end
  end

  // ---------------- tag pipe, retire, capture ----------------
  // Stage 0 samples the strobe as the core does, so r_due[LAST] lines up
  // with the cycle in which the core must present soe for that op.
  assign w_retire  = r_due[LAST];
  assign w_capture = r_due[LAST] & bus.core_soe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_due <= '0;
      for (int i = 0; i < CORE_LAT; i++) r_ptag[i] <= '0;
    end else begin
      r_due     <= {r_due[CORE_LAT-2:0], r_core_start};
      r_ptag[0] <= r_core_tag;
      for (int i = 1; i < CORE_LAT; i++) r_ptag[i] <= r_ptag[i-1];
    end
  end

  // A due op without soe is lost but still leaves the in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_flight <= '0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_cap_tag   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_in_flight <= r_in_flight + CNT_W'(w_accept) - CNT_W'(w_retire);
      r_cap_valid <= w_capture;
      if (w_capture) begin
        r_cap_data <= bus.core_out;
        r_cap_tag  <= r_ptag[LAST];
      end
      if (r_due[LAST] ^ bus.core_soe) r_err <= 1'b1;
    end
  end

  // ---------------- result FIFO ----------------
  assign w_pop = w_fifo_valid & bus.res_ready;

  fma_res_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_cap_valid),
    .i_data  ({r_cap_data, r_cap_tag}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  // ---------------- outputs ----------------
  assign bus.in_ready     = w_in_ready;
  assign bus.core_start   = r_core_start;
  assign bus.core_a       = r_core_a;
  assign bus.core_b       = r_core_b;
  assign bus.core_c       = r_core_c;
  assign bus.core_d       = r_core_d;
  assign bus.core_in_pre  = r_core_in_pre;
  assign bus.core_out_pre = r_core_out_pre;
  assign bus.res_valid    = w_fifo_valid;
  assign bus.res_data     = w_fifo_dout[EW-1:TAG_W];
  assign bus.res_tag      = w_fifo_dout[TAG_W-1:0];
  assign bus.err          = r_err;

  assign o_dbg_state     = r_state;
  assign o_dbg_in_flight = r_in_flight;

endmodule

// File: tb/tb_fma_issue_ctrl.sv
`timescale 1ns/1ps
module tb_fma_issue_ctrl;
  import fma_issue_ctrl_pkg::*;

  // A short core latency lets DEPTH=8 credits cover the full round trip,
  // so a continuous stream can issue one op per clock.
  localparam int CORE_LAT = 4;
  localparam int DEPTH    = 8;
  localparam int TAG_W    = 4;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int EW       = 32 + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();
  state_e           dbg_state;
  logic [CNT_W-1:0] dbg_in_flight;

  fma_issue_ctrl #(
    .CORE_LAT (CORE_LAT),
    .DEPTH    (DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .o_dbg_state     (dbg_state),
    .o_dbg_in_flight (dbg_in_flight)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  bit exp_en = 1'b1;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stand-in arithmetic for the core; any operand or precision corruption
  // on the way to the core changes the result.
  function automatic logic [31:0] core_fn(input logic [31:0] a, b, c, d,
                                          input logic [1:0] ip, op);
    return (a ^ b ^ c ^ d ^ 32'h4800_0000) + {28'd0, ip, op};
  endfunction

  // ---------------- FMA core model ----------------
  int   drop_req = 0;
  int   drop_done = 0;
  logic spur_soe = 1'b0;
  logic [CORE_LAT-1:0] m_v;
  logic [31:0] m_d [CORE_LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= '0;
      for (int i = 0; i < CORE_LAT; i++) m_d[i] <= '0;
    end else begin
      m_v <= {m_v[CORE_LAT-2:0], bus.core_start & !(drop_req > drop_done)};
      if (bus.core_start && (drop_req > drop_done)) drop_done <= drop_done + 1;
      m_d[0] <= core_fn(bus.core_a, bus.core_b, bus.core_c, bus.core_d,
                        bus.core_in_pre, bus.core_out_pre);
      for (int i = 1; i < CORE_LAT; i++) m_d[i] <= m_d[i-1];
    end
  end
  assign bus.core_soe = m_v[CORE_LAT-1] | spur_soe;
  assign bus.core_out = m_d[CORE_LAT-1];

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (bus.core_start) n_start++;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got data 0x%0h tag %0d, expected no result",
                 bus.res_data, bus.res_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", 64'(bus.res_data), 64'(mon_e[EW-1:TAG_W]));
        check("res_tag", 64'(bus.res_tag), 64'(mon_e[TAG_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic             post_start;
  logic [31:0]      post_a;
  logic [1:0]       post_in_pre;
  logic [CNT_W-1:0] pre_in_flight;
  state_e           pre_state;

  task automatic rand_fields(input logic [1:0] pre);
    bus.in_a       = $urandom;
    bus.in_b       = $urandom;
    bus.in_c       = $urandom;
    bus.in_d       = $urandom;
    bus.in_in_pre  = pre;
    bus.in_out_pre = 2'($urandom_range(0, 2));
    bus.in_tag     = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
  endtask

  // One clock: entered and left at a falling edge.
  task automatic step(output bit acc);
    #1;
    acc = bus.in_valid && bus.in_ready;
    pre_in_flight = dbg_in_flight;
    pre_state = dbg_state;
    @(posedge clk);
    if (acc && exp_en)
      exp_q.push_back({core_fn(bus.in_a, bus.in_b, bus.in_c, bus.in_d,
                               bus.in_in_pre, bus.in_out_pre), bus.in_tag});
    #1;
    post_start  = bus.core_start;
    post_a      = bus.core_a;
    post_in_pre = bus.core_in_pre;
    @(negedge clk);
  endtask

  task automatic send_n(input int cnt, input logic [1:0] pre, output int stalls);
    bit acc;
    int got = 0;
    int cyc = 0;
    stalls = 0;
    rand_fields(pre);
    bus.in_valid = 1'b1;
    while (got < cnt && cyc < cnt + 100) begin
      step(acc);
      cyc++;
      if (acc) begin
        got++;
        rand_fields(pre);
      end else if (got > 0) begin
        stalls++;
      end
    end
    bus.in_valid = 1'b0;
    check("send_n_accepted", 64'(got), 64'(cnt));
  endtask

  task automatic offer(input int n, input logic [1:0] pre, output int acc_n);
    bit acc;
    acc_n = 0;
    rand_fields(pre);
    bus.in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      step(acc);
      if (acc) begin
        acc_n++;
        rand_fields(pre);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    bus.res_ready = 1'b1;
    while ((exp_q.size() != 0 || dbg_in_flight != 0 || bus.res_valid) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int stalls;
    int acc_n;
    int lat;
    int waited;
    bit saw_drain;
    int start_base;

    bus.in_valid   = 1'b0;
    bus.res_ready  = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_c       = '0;
    bus.in_d       = '0;
    bus.in_in_pre  = '0;
    bus.in_out_pre = '0;
    bus.in_tag     = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_core_start", 64'(bus.core_start), 64'd0);
    check("rst_core_ab", {bus.core_a, bus.core_b}, 64'd0);
    check("rst_core_cd", {bus.core_c, bus.core_d}, 64'd0);
    check("rst_core_pre", 64'({bus.core_in_pre, bus.core_out_pre}), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_res_tag", 64'(bus.res_tag), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Single op, latency and hold behaviour
    bus.in_a = 32'h4000_0000; bus.in_b = 32'h4000_0000;
    bus.in_c = 32'h4000_0000; bus.in_d = 32'h4000_0000;
    bus.in_in_pre = 2'd0; bus.in_out_pre = 2'd0; bus.in_tag = 4'd3;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(acc);
    bus.in_valid = 1'b0;
    check("single_accepted", 64'(acc), 64'd1);
    check("single_core_start", 64'(post_start), 64'd1);
    check("single_core_a", 64'(post_a), 64'h4000_0000);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        check("start_one_cycle", 64'(bus.core_start), 64'd0);
        check("core_a_hold", 64'(bus.core_a), 64'h4000_0000);
      end
      if (bus.res_valid) lat = k;
    end
    check("single_latency", 64'(lat), 64'(CORE_LAT + 2));
    check("single_res_data", 64'(bus.res_data), 64'h4800_0000);
    check("single_res_tag", 64'(bus.res_tag), 64'd3);
    @(negedge clk);
    wait_drain();

    // Back-to-back 20 ops with res_ready held high
    start_base = n_start;
    bus.res_ready = 1'b1;
    send_n(20, 2'd0, stalls);
    check("b2b_stalls", 64'(stalls), 64'd0);
    wait_drain();
    check("b2b_start_count", 64'(n_start - start_base), 64'd20);
    check("b2b_err", 64'(bus.err), 64'd0);

    // Credit limit with the host not popping
    bus.res_ready = 1'b0;
    offer(30, 2'd0, acc_n);
    check("credit_fill", 64'(acc_n), 64'(DEPTH));
    check("credit_fifo_full_valid", 64'(bus.res_valid), 64'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    offer(20, 2'd0, acc_n);
    check("credit_one_more", 64'(acc_n), 64'd1);
    wait_drain();

    // Precision switch 0 -> 1 with three ops in flight
    bus.res_ready = 1'b1;
    send_n(3, 2'd0, stalls);
    rand_fields(2'd1);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    waited = 0;
    saw_drain = 1'b0;
    while (!acc && waited < 100) begin
      step(acc);
      if (pre_state == DRAIN) saw_drain = 1'b1;
      if (!acc) waited++;
    end
    bus.in_valid = 1'b0;
    check("pre_switch_accepted", 64'(acc), 64'd1);
    check("pre_switch_inflight", 64'(pre_in_flight), 64'd0);
    check("pre_switch_held", 64'(waited >= CORE_LAT), 64'd1);
    check("pre_switch_drain_seen", 64'(saw_drain), 64'd1);
    check("pre_switch_start", 64'(post_start), 64'd1);
    check("pre_switch_core_pre", 64'(post_in_pre), 64'd1);
    wait_drain();

    // Dropped soe
    drop_req++;
    exp_en = 1'b0;
    send_n(1, 2'd1, stalls);
    exp_en = 1'b1;
    repeat (CORE_LAT + 6) @(negedge clk);
    check("drop_err", 64'(bus.err), 64'd1);
    check("drop_inflight", 64'(dbg_in_flight), 64'd0);
    check("drop_no_result", 64'(bus.res_valid), 64'd0);
    do_reset();
    check("err_cleared_by_reset", 64'(bus.err), 64'd0);

    // Spurious soe while idle
    spur_soe = 1'b1;
    @(negedge clk);
    spur_soe = 1'b0;
    repeat (2) @(negedge clk);
    check("spurious_err", 64'(bus.err), 64'd1);
    check("spurious_no_result", 64'(bus.res_valid), 64'd0);
    do_reset();

    // Reset with four ops in flight
    bus.res_ready = 1'b1;
    send_n(4, 2'd2, stalls);
    check("midrst_inflight_before", 64'(dbg_in_flight), 64'd4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_core_start", 64'(bus.core_start), 64'd0);
    check("midrst_core_ab", {bus.core_a, bus.core_b}, 64'd0);
    check("midrst_core_pre", 64'({bus.core_in_pre, bus.core_out_pre}), 64'd0);
    check("midrst_res_valid", 64'(bus.res_valid), 64'd0);
    check("midrst_res_data", 64'(bus.res_data), 64'd0);
    check("midrst_inflight", 64'(dbg_in_flight), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_n(1, 2'd0, stalls);
    wait_drain();
    check("post_rst_err", 64'(bus.err), 64'd0);

    // Random mixed traffic with random host backpressure
    for (int r = 0; r < 6; r++) begin
      bus.res_ready = 1'($urandom_range(0, 1));
      offer($urandom_range(5, 15), 2'($urandom_range(0, 2)), acc_n);
    end
    wait_drain();
    check("final_err", 64'(bus.err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
